// File: rtl/uart_rx_cmd.sv
// 8N1 serial receiver with a single-character drive-command decoder.
// Bytes are strobed on rxValid; P/L/R/S (either case) set cmdDir one clk later,
// CR/LF are ignored silently, and anything else pulses cmdErr.
module uart_rx_cmd #(
  parameter int unsigned BIT_DIV  = 434,  // clk cycles per bit, 16..8191
  parameter int unsigned HALF_DIV = 217   // falling edge to start-bit midpoint, BIT_DIV/2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxData,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       frameErr,
  output logic [1:0] cmdDir,
  output logic       cmdValid,
  output logic       cmdErr
);

  // Direction codes shared with the nav logic
  localparam logic [1:0] DC_PROCEED    = 2'd0;
  localparam logic [1:0] DC_TURN_LEFT  = 2'd1;
  localparam logic [1:0] DC_TURN_RIGHT = 2'd2;
  localparam logic [1:0] DC_STOP       = 2'd3;

  localparam logic [12:0] BitLast  = 13'(BIT_DIV - 1);
  localparam logic [12:0] HalfLast = 13'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t      state;
  logic [12:0] cnt;
  logic [2:0]  bitIdx;
  logic [7:0]  shift;

  logic rxMeta, rxS, rxPrev;
  logic [1:0] primeCnt;
  logic fallEdge;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta   <= 1'b1;
      rxS      <= 1'b1;
      rxPrev   <= 1'b1;
      primeCnt <= 2'd0;
    end else begin
      rxMeta <= rxData;
      rxS    <= rxMeta;
      rxPrev <= rxS;
      if (primeCnt != 2'd3) primeCnt <= primeCnt + 2'd1;
    end
  end

  // The reset value of the history flop is not a real line sample; ignore edges until the
  // pipeline holds genuine samples so a line held low across reset release is not a start bit.
  assign fallEdge = (primeCnt == 2'd3) && rxPrev && !rxS;

  // Receive FSM with bit timing, shift register and registered byte/error strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 13'd0;
      bitIdx   <= 3'd0;
      shift    <= 8'h00;
      rxByte   <= 8'h00;
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= 13'd0;
          if (fallEdge) state <= START;
        end
        START: begin
          if (cnt == HalfLast) begin
            cnt <= 13'd0;
            if (!rxS) begin
              state  <= DATA;
              bitIdx <= 3'd0;
            end else begin
              state <= IDLE;  // glitch shorter than half a bit
            end
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        DATA: begin
          if (cnt == BitLast) begin
            cnt    <= 13'd0;
            shift  <= {rxS, shift[7:1]};  // LSB arrives first
            bitIdx <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        STOP: begin
          if (cnt == BitLast) begin
            cnt <= 13'd0;
            if (rxS) begin
              rxByte  <= shift;
              rxValid <= 1'b1;
              state   <= IDLE;  // leave at mid-stop so a back-to-back start edge is caught
            end else begin
              frameErr <= 1'b1;
              state    <= BRK;
            end
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        BRK: begin
          if (rxS) begin
            cnt   <= 13'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 13'd1;
          end
        end
        default: begin
          cnt   <= 13'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Command decoder, one clk behind rxValid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmdDir   <= DC_STOP;
      cmdValid <= 1'b0;
      cmdErr   <= 1'b0;
    end else begin
      cmdValid <= 1'b0;
      cmdErr   <= 1'b0;
      if (rxValid) begin
        case (rxByte)
          8'h50, 8'h70: begin  // 'P' 'p'
            cmdDir   <= DC_PROCEED;
            cmdValid <= 1'b1;
          end
          8'h4C, 8'h6C: begin  // 'L' 'l'
            cmdDir   <= DC_TURN_LEFT;
            cmdValid <= 1'b1;
          end
          8'h52, 8'h72: begin  // 'R' 'r'
            cmdDir   <= DC_TURN_RIGHT;
            cmdValid <= 1'b1;
          end
          8'h53, 8'h73: begin  // 'S' 's'
            cmdDir   <= DC_STOP;
            cmdValid <= 1'b1;
          end
          8'h0D, 8'h0A: ;  // CR / LF from the terminal
          default: cmdErr <= 1'b1;
        endcase
      end
    end
  end

endmodule
